// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle,
// magnitudes in the datapath, sign correction applied on completion.
module muldiv_unit #(
   parameter int BITS  = 32,
   parameter int CNT_W = $clog2(BITS) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [4:0]      alu_ctrl,
   input  logic [BITS-1:0] op_a,
   input  logic [BITS-1:0] op_b,
   input  logic            flush,
   output logic            in_ready,
   output logic            busy,
   output logic            out_valid,
   output logic [BITS-1:0] result
);

   localparam logic [4:0] ALUCTRL_MUL    = 5'h10;
   localparam logic [4:0] ALUCTRL_MULH   = 5'h11;
   localparam logic [4:0] ALUCTRL_MULHSU = 5'h12;
   localparam logic [4:0] ALUCTRL_MULHU  = 5'h13;
   localparam logic [4:0] ALUCTRL_DIV    = 5'h14;
   localparam logic [4:0] ALUCTRL_DIVU   = 5'h15;
   localparam logic [4:0] ALUCTRL_REM    = 5'h16;
   localparam logic [4:0] ALUCTRL_REMU   = 5'h17;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic             is_m, d_div, d_rem, d_hi, sa_sgn, sb_sgn;
   logic             neg_a, neg_b, div_zero, ovf, special, accept;
   logic [BITS-1:0]  mag_a, mag_b, spec_val;

   logic             r_div, r_rem, r_hi, r_spec, r_neg;
   logic [BITS-1:0]  opnd;
   logic [2*BITS-1:0] acc, acc_step;
   logic [CNT_W-1:0] cnt;

   logic [BITS:0]     sum, r2;
   logic [BITS-1:0]   diff, new_hi, div_sel, div_res;
   logic              ge;
   logic [2*BITS-1:0] prod;
   logic [BITS-1:0]   fin;

   always_comb begin
      is_m   = 1'b0;
      d_div  = 1'b0;
      d_rem  = 1'b0;
      d_hi   = 1'b0;
      sa_sgn = 1'b0;
      sb_sgn = 1'b0;
      unique case (alu_ctrl)
         ALUCTRL_MUL:    begin is_m = 1'b1; sa_sgn = 1'b1; sb_sgn = 1'b1; end
         ALUCTRL_MULH:   begin is_m = 1'b1; d_hi = 1'b1;
                               sa_sgn = 1'b1; sb_sgn = 1'b1; end
         ALUCTRL_MULHSU: begin is_m = 1'b1; d_hi = 1'b1; sa_sgn = 1'b1; end
         ALUCTRL_MULHU:  begin is_m = 1'b1; d_hi = 1'b1; end
         ALUCTRL_DIV:    begin is_m = 1'b1; d_div = 1'b1;
                               sa_sgn = 1'b1; sb_sgn = 1'b1; end
         ALUCTRL_DIVU:   begin is_m = 1'b1; d_div = 1'b1; end
         ALUCTRL_REM:    begin is_m = 1'b1; d_div = 1'b1; d_rem = 1'b1;
                               sa_sgn = 1'b1; sb_sgn = 1'b1; end
         ALUCTRL_REMU:   begin is_m = 1'b1; d_div = 1'b1; d_rem = 1'b1; end
         default: ;
      endcase
   end

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready && !flush && is_m;

   assign neg_a    = sa_sgn & op_a[BITS-1];
   assign neg_b    = sb_sgn & op_b[BITS-1];
   assign mag_a    = neg_a ? -op_a : op_a;
   assign mag_b    = neg_b ? -op_b : op_b;
   assign div_zero = d_div && (op_b == '0);
   assign ovf      = d_div && sa_sgn && (op_b == '1)
                  && (op_a == {1'b1, {(BITS-1){1'b0}}});
   assign special  = div_zero || ovf;

   // Both special results are known at accept time, so they bypass BUSY.
   always_comb begin
      if (div_zero)
         spec_val = d_rem ? op_a : '1;
      else
         spec_val = d_rem ? '0 : op_a;
   end

   always_comb begin
      sum = {1'b0, acc[2*BITS-1:BITS]} + (acc[0] ? {1'b0, opnd} : '0);
      r2  = {acc[2*BITS-1:BITS], acc[BITS-1]};
      ge  = (r2 >= {1'b0, opnd});
      // Remainder always fits BITS bits after a successful subtract.
      diff   = r2[BITS-1:0] - opnd;
      new_hi = ge ? diff : r2[BITS-1:0];
      if (r_div)
         acc_step = {new_hi, acc[BITS-2:0], ge};
      else
         acc_step = {sum, acc[BITS-1:1]};
   end

   always_comb begin
      prod    = r_neg ? -acc : acc;
      div_sel = r_rem ? acc[2*BITS-1:BITS] : acc[BITS-1:0];
      div_res = r_neg ? -div_sel : div_sel;
      if (r_spec)
         fin = acc[BITS-1:0];
      else if (r_div)
         fin = div_res;
      else if (r_hi)
         fin = prod[2*BITS-1:BITS];
      else
         fin = prod[BITS-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = special ? DONE : BUSY;
         BUSY: begin
            if (flush)
               state_nxt = IDLE;
            else if (cnt == CNT_W'(BITS - 1))
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         acc       <= '0;
         opnd      <= '0;
         r_div     <= 1'b0;
         r_rem     <= 1'b0;
         r_hi      <= 1'b0;
         r_spec    <= 1'b0;
         r_neg     <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
      end else begin
         out_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  cnt    <= '0;
                  r_div  <= d_div;
                  r_rem  <= d_rem;
                  r_hi   <= d_hi;
                  r_spec <= special;
                  r_neg  <= d_rem ? neg_a : (neg_a ^ neg_b);
                  opnd   <= d_div ? mag_b : mag_a;
                  if (special)
                     acc <= {{BITS{1'b0}}, spec_val};
                  else
                     acc <= {{BITS{1'b0}}, d_div ? mag_a : mag_b};
               end
            end
            BUSY: begin
               acc <= acc_step;
               cnt <= cnt + CNT_W'(1);
            end
            DONE: begin
               if (!flush) begin
                  result    <= fin;
                  out_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, abort paths
// and randomized ops against a plain-arithmetic reference model.
module tb_muldiv_unit;

   localparam int BITS = 32;
   localparam logic [4:0] C_ADD    = 5'h00;
   localparam logic [4:0] C_NOP    = 5'h1f;
   localparam logic [4:0] C_MUL    = 5'h10;
   localparam logic [4:0] C_MULH   = 5'h11;
   localparam logic [4:0] C_MULHSU = 5'h12;
   localparam logic [4:0] C_MULHU  = 5'h13;
   localparam logic [4:0] C_DIV    = 5'h14;
   localparam logic [4:0] C_DIVU   = 5'h15;
   localparam logic [4:0] C_REM    = 5'h16;
   localparam logic [4:0] C_REMU   = 5'h17;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic [4:0]      alu_ctrl;
   logic [BITS-1:0] op_a;
   logic [BITS-1:0] op_b;
   logic            flush;
   logic            in_ready;
   logic            busy;
   logic            out_valid;
   logic [BITS-1:0] result;

   int total = 0;
   int bad   = 0;
   logic [31:0] last_res;

   always #5 clk = ~clk;

   muldiv_unit #(.BITS(BITS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .alu_ctrl(alu_ctrl),
      .op_a(op_a), .op_b(op_b), .flush(flush), .in_ready(in_ready),
      .busy(busy), .out_valid(out_valid), .result(result)
   );

   function automatic logic [31:0] model(input logic [4:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, ua, ub, p;
      logic ov;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      ov = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
      p  = 0;
      model = '0;
      case (op)
         C_MUL:    begin p = sa * sb; model = p[31:0];  end
         C_MULH:   begin p = sa * sb; model = p[63:32]; end
         C_MULHSU: begin p = sa * ub; model = p[63:32]; end
         C_MULHU:  begin p = ua * ub; model = p[63:32]; end
         C_DIV: begin
            if (b == 0) model = 32'hffff_ffff;
            else if (ov) model = a;
            else begin p = sa / sb; model = p[31:0]; end
         end
         C_DIVU: begin
            if (b == 0) model = 32'hffff_ffff;
            else begin p = ua / ub; model = p[31:0]; end
         end
         C_REM: begin
            if (b == 0) model = a;
            else if (ov) model = 32'h0;
            else begin p = sa % sb; model = p[31:0]; end
         end
         C_REMU: begin
            if (b == 0) model = a;
            else begin p = ua % ub; model = p[31:0]; end
         end
         default: model = '0;
      endcase
   endfunction

   function automatic int exp_lat(input logic [4:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      logic is_div, is_sdiv;
      is_div  = (op == C_DIV) || (op == C_DIVU)
             || (op == C_REM) || (op == C_REMU);
      is_sdiv = (op == C_DIV) || (op == C_REM);
      if (is_div && b == 0) return 1;
      if (is_sdiv && a == 32'h8000_0000 && b == 32'hffff_ffff) return 1;
      return 33;
   endfunction

   // Presents one op from the current time; accept edge is the next posedge.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res,
                         output int lat, output int bcnt, output bit got);
      alu_ctrl = op;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      alu_ctrl = C_NOP;
      got  = 1'b0;
      lat  = 0;
      res  = '0;
      bcnt = busy ? 1 : 0;
      for (int i = 1; i <= 100 && !got; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            got = 1'b1;
            lat = i;
            res = result;
         end else if (busy) begin
            bcnt++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
      alu_ctrl = C_NOP; op_a = '0; op_b = '0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++;
         $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (busy !== 1'b0) begin bad++;
         $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (out_valid !== 1'b0) begin bad++;
         $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (result !== 32'h0) begin bad++;
         $display("FAIL reset_result got=%h exp=0", result); end
      rst = 1'b0;
      last_res = 32'h0;
   endtask

   task automatic test_mul_latency();
      logic [31:0] r; int lat, bc; bit got;
      @(negedge clk);
      run_op(C_MUL, 32'd7, 32'hffff_fffd, r, lat, bc, got);
      total++; if (got !== 1'b1) begin bad++;
         $display("FAIL mul_timeout got=%b exp=1", got); end
      total++; if (r !== 32'hffff_ffeb) begin bad++;
         $display("FAIL mul_result got=%h exp=ffffffeb", r); end
      total++; if (lat != 33) begin bad++;
         $display("FAIL mul_latency got=%0d exp=33", lat); end
      total++; if (bc != 33) begin bad++;
         $display("FAIL mul_busy_cycles got=%0d exp=33", bc); end
      last_res = 32'hffff_ffeb;
   endtask

   task automatic test_directed(input string tag, input logic [4:0] ops[4],
                                input logic [31:0] as[4],
                                input logic [31:0] bs[4],
                                input logic [31:0] ex[4],
                                input int el, input int n);
      logic [31:0] r; int lat, bc; bit got;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         run_op(ops[i], as[i], bs[i], r, lat, bc, got);
         total++; if (got !== 1'b1 || r !== ex[i]) begin bad++;
            $display("FAIL %s_%0d_result got=%h exp=%h", tag, i, r, ex[i]); end
         total++; if (lat != el) begin bad++;
            $display("FAIL %s_%0d_latency got=%0d exp=%0d", tag, i, lat, el); end
         last_res = ex[i];
      end
   endtask

   task automatic test_high_mul();
      logic [4:0]  o[4] = '{C_MULH, C_MULHU, C_MULHSU, C_NOP};
      logic [31:0] a[4] = '{32'h8000_0000, 32'hffff_ffff, 32'hffff_ffff, 0};
      logic [31:0] b[4] = '{32'h8000_0000, 32'hffff_ffff, 32'hffff_ffff, 0};
      logic [31:0] e[4] = '{32'h4000_0000, 32'hffff_fffe, 32'hffff_ffff, 0};
      test_directed("mulh", o, a, b, e, 33, 3);
   endtask

   task automatic test_divide();
      logic [4:0]  o[4] = '{C_DIV, C_REM, C_DIVU, C_REMU};
      logic [31:0] a[4] = '{32'hffff_fff9, 32'hffff_fff9, 32'd100, 32'd100};
      logic [31:0] b[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
      logic [31:0] e[4] = '{32'hffff_fffd, 32'hffff_ffff, 32'd14, 32'd2};
      test_directed("div", o, a, b, e, 33, 4);
   endtask

   task automatic test_special();
      logic [4:0]  o[4] = '{C_DIV, C_REMU, C_DIV, C_REM};
      logic [31:0] a[4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] b[4] = '{32'd0, 32'd0, 32'hffff_ffff, 32'hffff_ffff};
      logic [31:0] e[4] = '{32'hffff_ffff, 32'd5, 32'h8000_0000, 32'd0};
      test_directed("spec", o, a, b, e, 1, 4);
   endtask

   task automatic test_random();
      logic [4:0] codes[8] = '{C_MUL, C_MULH, C_MULHSU, C_MULHU,
                               C_DIV, C_DIVU, C_REM, C_REMU};
      logic [4:0] op; logic [31:0] a, b, ex, r;
      int lat, bc, k; bit got;
      for (int i = 0; i < 60; i++) begin
         op = codes[$urandom_range(0, 7)];
         a  = $urandom;
         b  = $urandom;
         k  = $urandom_range(0, 9);
         if (k == 0) b = 32'h0;
         if (k == 1) begin a = 32'h8000_0000; b = 32'hffff_ffff; end
         if (k == 2) b = $urandom_range(1, 15);
         if (k == 3) a = $urandom_range(0, 3);
         ex = model(op, a, b);
         @(negedge clk);
         run_op(op, a, b, r, lat, bc, got);
         total++; if (got !== 1'b1 || r !== ex) begin bad++;
            $display("FAIL rand_%0d op=%h a=%h b=%h got=%h exp=%h",
                     i, op, a, b, r, ex); end
         total++; if (lat != exp_lat(op, a, b)) begin bad++;
            $display("FAIL rand_lat_%0d op=%h got=%0d exp=%0d",
                     i, op, lat, exp_lat(op, a, b)); end
         last_res = ex;
      end
   endtask

   task automatic test_flush();
      logic [31:0] r; int lat, bc, seen; bit got;
      @(negedge clk);
      run_op(C_MUL, 32'd9, 32'd9, r, lat, bc, got);
      total++; if (r !== 32'd81) begin bad++;
         $display("FAIL flush_setup got=%h exp=51", r); end
      last_res = 32'd81;
      @(negedge clk);
      alu_ctrl = C_DIVU; op_a = 32'd1000; op_b = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++;
         $display("FAIL flush_busy_idle got=%b%b exp=10", in_ready, busy); end
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
      total++; if (seen != 0) begin bad++;
         $display("FAIL flush_busy_no_valid got=%0d exp=0", seen); end
      total++; if (result !== last_res) begin bad++;
         $display("FAIL flush_busy_result got=%h exp=%h", result, last_res); end
      @(negedge clk);
      alu_ctrl = C_MUL; op_a = 32'd2; op_b = 32'd2;
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      total++; if (busy !== 1'b0) begin bad++;
         $display("FAIL flush_idle_accept got=%b exp=0", busy); end
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
      total++; if (seen != 0) begin bad++;
         $display("FAIL flush_idle_no_valid got=%0d exp=0", seen); end
      @(negedge clk);
      alu_ctrl = C_DIV; op_a = 32'd5; op_b = 32'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
         $display("FAIL flush_done got=%b%b exp=01", out_valid, in_ready); end
      total++; if (result !== last_res) begin bad++;
         $display("FAIL flush_done_result got=%h exp=%h", result, last_res); end
   endtask

   task automatic test_reset_mid();
      int seen;
      @(negedge clk);
      alu_ctrl = C_MUL; op_a = 32'd11; op_b = 32'd13; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      total++; if (in_ready !== 1'b1 || busy !== 1'b0
                   || out_valid !== 1'b0) begin bad++;
         $display("FAIL rst_mid_ctl got=%b%b%b exp=100",
                  in_ready, busy, out_valid); end
      total++; if (result !== 32'h0) begin bad++;
         $display("FAIL rst_mid_result got=%h exp=0", result); end
      last_res = 32'h0;
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
      total++; if (seen != 0) begin bad++;
         $display("FAIL rst_mid_no_valid got=%0d exp=0", seen); end
   endtask

   task automatic test_ignored();
      int bsy, ov;
      bsy = 0; ov = 0;
      @(negedge clk);
      alu_ctrl = C_ADD; op_a = 32'd3; op_b = 32'd4; in_valid = 1'b1;
      repeat (3) begin @(posedge clk); #1; if (busy) bsy++; if (out_valid) ov++; end
      alu_ctrl = C_NOP;
      repeat (3) begin @(posedge clk); #1; if (busy) bsy++; if (out_valid) ov++; end
      in_valid = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (busy) bsy++; if (out_valid) ov++; end
      total++; if (bsy != 0) begin bad++;
         $display("FAIL ignored_busy got=%0d exp=0", bsy); end
      total++; if (ov != 0) begin bad++;
         $display("FAIL ignored_out_valid got=%0d exp=0", ov); end
      total++; if (result !== last_res) begin bad++;
         $display("FAIL ignored_result got=%h exp=%h", result, last_res); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r; int lat, bc; bit got;
      @(negedge clk);
      run_op(C_MUL, 32'd3, 32'd4, r, lat, bc, got);
      total++; if (got !== 1'b1 || r !== 32'd12) begin bad++;
         $display("FAIL b2b_first got=%h exp=c", r); end
      total++; if (in_ready !== 1'b1) begin bad++;
         $display("FAIL b2b_ready got=%b exp=1", in_ready); end
      run_op(C_MUL, 32'd5, 32'd6, r, lat, bc, got);
      total++; if (got !== 1'b1 || r !== 32'd30) begin bad++;
         $display("FAIL b2b_second got=%h exp=1e", r); end
      total++; if (lat != 33 || bc != 33) begin bad++;
         $display("FAIL b2b_timing got=%0d/%0d exp=33/33", lat, bc); end
   endtask

   initial begin
      test_reset();
      test_mul_latency();
      test_high_mul();
      test_divide();
      test_special();
      test_random();
      test_flush();
      test_reset_mid();
      test_ignored();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
